mont_prod: RTL

Bit-serial Montgomery multiplier for the 256-bit RSA datapath. It computes o_m = a·b·2^-WIDTH mod N, one radix-2 iteration per clock. It sits directly downstream of the modular pre-product stage, which supplies the Montgomery-domain operand y·2^256 mod N. The RSA core calls it repeatedly for the square-and-multiply loop.

---
 rtl/mont_prod.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mont_prod.sv
// mont_prod: bit-serial radix-2 Montgomery multiplier.
// Computes o_m = a * b * 2^-WIDTH mod N. Each clock performs one iteration,
// and the multiplier bits of a are consumed LSB first.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  start request, honoured only while idle
//   i_n      odd modulus N, held stable until o_end
//   i_a      operand a (< N), captured on the accepting edge
//   i_b      operand b (< N), captured on the accepting edge
//   o_m      result, held until the next completion
//   o_end    single-cycle completion pulse, o_m valid in the same cycle
//   o_busy   high from the accepting edge until o_end rises
module mont_prod #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_m,
    output logic             o_end,
    output logic             o_busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // The accumulator stays below 2N, so every intermediate sum is below 4N
    // and fits in two extra bits.
    localparam int unsigned MW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [MW-1:0]    m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] om_q, om_d;
    logic             end_q, end_d;
    logic             busy_q, busy_d;

    logic [MW-1:0] n_ext;
    logic [MW-1:0] t_add;
    logic [MW-1:0] t_red;
    logic [MW-1:0] m_sub;

    always_comb begin
        n_ext = {2'b00, n_q};
        // a is shifted right every iteration, so a_q[0] is always bit i.
        t_add = m_q + (a_q[0] ? {2'b00, b_q} : '0);
        // Adding the odd modulus makes the sum even, so the shift is exact.
        t_red = t_add[0] ? (t_add + n_ext) : t_add;
        m_sub = m_q - n_ext;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        om_d    = om_q;
        end_d   = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    n_d     = i_n;
                    m_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                m_d = t_red >> 1;
                a_d = a_q >> 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                om_d    = (m_q >= n_ext) ? m_sub[WIDTH-1:0] : m_q[WIDTH-1:0];
                end_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            om_q    <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            om_q    <= om_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    assign o_m    = om_q;
    assign o_end  = end_q;
    assign o_busy = busy_q;

endmodule
